// File: rtl/instr_fetch_unit_if.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit_if
// Bundles the control-unit side and the byte-wide memory side of the
// instruction fetch unit.
//   Control side : fetch_req, pc (to unit); busy, instr, op/funct/rs/rt/rd/imm,
//                  ir_we, instr_valid, fault (from unit)
//   Memory side  : mem_rd, mem_addr (from unit); mem_ack, mem_rdata (to unit)
// Modports:
//   slave  - the fetch unit itself
//   master - whatever drives requests and models the memory
// -----------------------------------------------------------------------------
interface instr_fetch_unit_if #(
   parameter int ADDR_W = 8
);
   logic              fetch_req;
   logic [ADDR_W-1:0] pc;
   logic              busy;
   logic              mem_rd;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_ack;
   logic [7:0]        mem_rdata;
   logic [3:0]        ir_we;
   logic [31:0]       instr;
   logic [5:0]        op;
   logic [5:0]        funct;
   logic [4:0]        rs;
   logic [4:0]        rt;
   logic [4:0]        rd;
   logic [15:0]       imm;
   logic              instr_valid;
   logic              fault;

   modport slave (
      input  fetch_req, pc, mem_ack, mem_rdata,
      output busy, mem_rd, mem_addr, ir_we, instr, op, funct, rs, rt, rd, imm,
             instr_valid, fault
   );

   modport master (
      output fetch_req, pc, mem_ack, mem_rdata,
      input  busy, mem_rd, mem_addr, ir_we, instr, op, funct, rs, rt, rd, imm,
             instr_valid, fault
   );
endinterface

// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
// Fetches a 32-bit big-endian instruction one byte at a time from a byte-wide
// memory and assembles it in an instruction register with decoded fields.
//   clk  - rising-edge system clock
//   rst  - asynchronous active-high reset
//   bus  - instr_fetch_unit_if.slave (request, memory and result signals)
// Parameters:
//   ADDR_W  - byte-address width of the instruction memory
//   TIMEOUT - READ cycles without mem_ack before the fetch is aborted
// Optional feature (macro IFU_TIMEOUT_EN): a wait counter aborts a stuck fetch
// and raises a sticky fault. Without the macro READ waits forever and fault
// is tied low.
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
   parameter int ADDR_W  = 8,
   parameter int TIMEOUT = 15
) (
   input  logic               clk,
   input  logic               rst,
   instr_fetch_unit_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      READ = 2'b01,
      DONE = 2'b10
   } state_t;

   state_t            state_q, state_d;
   logic [1:0]        index_q, index_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic [31:0]       instr_q, instr_d;
   logic [3:0]        ir_we_q, ir_we_d;
   logic [1:0]        lane;

   // Byte 0 of the fetch lands in the most significant lane.
   assign lane = 2'd3 - index_q;

   if (TIMEOUT < 1) begin : g_timeout_range
      $error("instr_fetch_unit: TIMEOUT must be at least 1");
   end

`ifdef IFU_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT + 1);
   logic [TMO_W-1:0] tmo_q, tmo_d;
   logic             fault_q, fault_d;
`endif

   always_comb begin
      // NOTE: every next-state signal gets a default first so no path through
      // the case statement can leave one unassigned and infer a latch.
      state_d = state_q;
      index_d = index_q;
      base_d  = base_q;
      instr_d = instr_q;
      ir_we_d = '0;
`ifdef IFU_TIMEOUT_EN
      tmo_d   = tmo_q;
      fault_d = fault_q;
`endif
      case (state_q)
         IDLE, DONE: begin
            if (bus.fetch_req) begin
               state_d = READ;
               base_d  = bus.pc;
               index_d = '0;
`ifdef IFU_TIMEOUT_EN
               tmo_d   = '0;
               fault_d = 1'b0;
`endif
            end else begin
               state_d = IDLE;
            end
         end
         READ: begin
            if (bus.mem_ack) begin
               instr_d[{lane, 3'b000} +: 8] = bus.mem_rdata;
               ir_we_d = 4'b0001 << lane;
`ifdef IFU_TIMEOUT_EN
               tmo_d   = '0;
`endif
               if (index_q == 2'd3) begin
                  state_d = DONE;
               end else begin
                  index_d = index_q + 2'd1;
               end
            end
`ifdef IFU_TIMEOUT_EN
            // This cycle is the TIMEOUT-th consecutive one without an ack.
            else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
               state_d = IDLE;
               fault_d = 1'b1;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
`endif
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         index_q <= '0;
         base_q  <= '0;
         instr_q <= '0;
         ir_we_q <= '0;
`ifdef IFU_TIMEOUT_EN
         tmo_q   <= '0;
         fault_q <= 1'b0;
`endif
      end else begin
         // NOTE: non-blocking assignments so every register samples the
         // pre-edge value of the others, independent of statement order.
         state_q <= state_d;
         index_q <= index_d;
         base_q  <= base_d;
         instr_q <= instr_d;
         ir_we_q <= ir_we_d;
`ifdef IFU_TIMEOUT_EN
         tmo_q   <= tmo_d;
         fault_q <= fault_d;
`endif
      end
   end

   assign bus.busy        = (state_q != IDLE);
   assign bus.mem_rd      = (state_q == READ);
   // Address is forced to zero outside READ so the memory bus stays quiet.
   assign bus.mem_addr    = (state_q == READ) ? base_q + ADDR_W'(index_q) : '0;
   assign bus.instr_valid = (state_q == DONE);
   assign bus.ir_we       = ir_we_q;
   assign bus.instr       = instr_q;
   assign bus.op          = instr_q[31:26];
   assign bus.funct       = instr_q[5:0];
   assign bus.rs          = instr_q[25:21];
   assign bus.rt          = instr_q[20:16];
   assign bus.rd          = instr_q[15:11];
   assign bus.imm         = instr_q[15:0];
`ifdef IFU_TIMEOUT_EN
   assign bus.fault       = fault_q;
`else
   assign bus.fault       = 1'b0;
`endif

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameter: ADDR_W, 8, byte-address width of the instruction memory.
REQ-002 Parameter: TIMEOUT, 15, max READ cycles without mem_ack before abort (only used under IFU_TIMEOUT_EN).
REQ-003 One clock, reset asynchronous active-high.
REQ-004 clock  in  1  rising-edge system clock.
REQ-005 reset  in  1  asynchronous active-high reset.
REQ-006 fetch_req  in  1  control-unit request to fetch the instruction at pc; sampled on a rising edge.
REQ-007 pc  in  ADDR_W  byte address of the instruction's first byte.
REQ-008 busy  out  1  high in any state other than IDLE.
REQ-009 mem_rd  out  1  byte read request to memory.
REQ-010 mem_addr  out  ADDR_W  byte address for the current read.
REQ-011 mem_ack  in  1  memory returns valid mem_rdata this cycle.
REQ-012 mem_rdata  in  8  read byte.
REQ-013 ir_we  out  4  registered one-hot byte-lane strobe, pulses for the lane written on each captured byte (IRWrite-compatible).
REQ-014 instr  out  32  assembled instruction register.
REQ-015 op/funct/rs/rt/rd/imm  out  6/6/5/5/5/16  decoded fields: instr[31:26], [5:0], [25:21], [20:16], [15:11], [15:0].
REQ-016 instr_valid  out  1  one-cycle pulse, instr complete.
REQ-017 fault  out  1  fetch aborted on timeout.

Function
REQ-018 FSM states IDLE, READ, DONE, encoded in 2 bits; illegal encoding returns to IDLE next edge.
REQ-019 IDLE: fetch_req=1 latches pc into base, clears byte index to 0, clears fault, goes to READ; otherwise stays in IDLE.
REQ-020 READ: mem_rd=1, mem_addr=(base+index) modulo 2^ADDR_W; no mem_ack means stay in READ with address held.
REQ-021 READ with mem_ack=1: mem_rdata written to instr lane (3-index), big-endian (byte at pc -> instr[31:24]); ir_we[3-index]=1 in the following cycle only.
REQ-022 READ with mem_ack=1 and index<3: index increments, stay in READ; index=3: go to DONE.
REQ-023 DONE: instr_valid=1, mem_rd=0; fetch_req=1 starts a new fetch exactly as from IDLE (back-to-back), else go to IDLE.
REQ-024 fetch_req ignored in READ; pc changes after latching have no effect.
REQ-025 Zero-wait latency: fetch_req sampled at edge N -> instr_valid high in the cycle after edge N+4; each wait cycle adds one cycle.
REQ-026 instr and fields hold their value until overwritten by a byte of a later fetch; decoded fields are combinational from instr.
REQ-027 mem_ack outside READ is ignored.

Reset
REQ-028 reset asserted at any time (including mid-fetch) forces state IDLE, index 0, base 0, instr 0, ir_we 0, mem_rd 0, mem_addr 0, instr_valid 0, fault 0, busy 0 immediately.
REQ-029 First fetch_req is accepted on the first rising edge with reset low.

Configuration
REQ-030 Macro IFU_TIMEOUT_EN defined: counter clears on entry to READ and on every mem_ack, increments each READ cycle without ack; reaching TIMEOUT -> go to IDLE, fault=1 (sticky until next accepted fetch_req), no instr_valid, partially written instr retained.
REQ-031 IFU_TIMEOUT_EN undefined: READ waits indefinitely, no counter logic, fault tied 0.

Verification
REQ-032 pc=0x10, memory 0x80,0xA2,0x00,0x04, ack every cycle -> mem_addr 0x10..0x13, ir_we 1000,0100,0010,0001, instr=0x80A20004, op=100000, rs=5, rt=2, imm=0x0004, instr_valid 5 cycles after request.
REQ-033 pc=0x20, bytes 0x00,0xA2,0x30,0x20, two wait cycles per byte -> op=000000, funct=100000, rd=6, instr_valid 13 cycles after request.
REQ-034 pc=0xFE -> mem_addr FE, FF, 00, 01.
REQ-035 fetch_req held high in DONE -> next fetch starts with no IDLE cycle; reset pulse after second byte -> all outputs 0 at once, next fetch correct.
REQ-036 IFU_TIMEOUT_EN defined, mem_ack held 0 -> after 15 READ cycles fault=1, busy=0, no instr_valid; next fetch_req clears fault.
